prbs_gen_par: RTL

Parallel multi-polynomial PRBS generator producing DATA_W pseudo-random bits per clock on a valid/ready stream. Successor to the single-bit fixed-polynomial PRBS15 source: polynomial selectable at run time (PRBS7/9/15/23/31), seed loadable, output backpressurable, with single-bit error injection for exercising downstream link checkers. Sits at the head of a serial-link test datapath, feeding a serializer or checker.

---
 rtl/prbs_gen_par.sv | 118 +++++++++++
 1 files changed

// File: rtl/prbs_gen_par.sv
// Parallel multi-polynomial Fibonacci PRBS generator: DATA_W bits per accepted word,
// run-time polynomial select, seed load, valid/ready output and single-word error injection.
module prbs_gen_par #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [2:0]        mode,
  input  logic              seed_load,
  input  logic [30:0]       seed,
  input  logic              err_inj,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       word_cnt
);

  logic [30:0]       lfsr_reg;
  logic [2:0]        mode_reg;
  logic              err_pend_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_valid_reg;
  logic [31:0]       word_cnt_reg;

  // Codes 5-7 fall into the default branch and behave as PRBS31.
  function automatic logic [30:0] poly_mask(input logic [2:0] m);
    case (m)
      3'd0:    poly_mask = 31'h0000_007F;
      3'd1:    poly_mask = 31'h0000_01FF;
      3'd2:    poly_mask = 31'h0000_7FFF;
      3'd3:    poly_mask = 31'h007F_FFFF;
      default: poly_mask = 31'h7FFF_FFFF;
    endcase
  endfunction

  logic [4:0]  len_m1;
  logic [4:0]  tap_m1;
  logic [30:0] act_mask;

  always_comb begin
    len_m1   = 5'd30;
    tap_m1   = 5'd27;
    act_mask = poly_mask(mode_reg);
    case (mode_reg)
      3'd0:    begin len_m1 = 5'd6;  tap_m1 = 5'd5;  end
      3'd1:    begin len_m1 = 5'd8;  tap_m1 = 5'd4;  end
      3'd2:    begin len_m1 = 5'd14; tap_m1 = 5'd13; end
      3'd3:    begin len_m1 = 5'd22; tap_m1 = 5'd17; end
      default: begin len_m1 = 5'd30; tap_m1 = 5'd27; end
    endcase
  end

  // Unrolled chain: element gi is the LFSR state after gi single-bit steps.
  logic [DATA_W:0][30:0] chain;
  logic [DATA_W-1:0]     word_next;

  assign chain[0] = lfsr_reg;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_step
    logic step_bit;
    assign step_bit                = chain[gi][len_m1] ^ chain[gi][tap_m1];
    assign chain[gi+1]             = {chain[gi][29:0], step_bit} & act_mask;
    assign word_next[DATA_W-1-gi]  = step_bit;
  end

  logic              adv;
  logic [DATA_W-1:0] word_out;
  logic [30:0]       seed_masked;
  logic [30:0]       seed_state;

  always_comb begin
    adv      = en & (~out_valid_reg | out_ready) & ~seed_load;
    word_out = word_next;
    word_out[DATA_W-1] = word_next[DATA_W-1] ^ (err_pend_reg | err_inj);
    seed_masked = seed & poly_mask(mode);
    // An all-zero state would lock the LFSR, so substitute all ones.
    seed_state  = (seed_masked == 31'd0) ? poly_mask(mode) : seed_masked;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_reg      <= 31'h0000_007F;
      mode_reg      <= 3'd0;
      err_pend_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      word_cnt_reg  <= 32'd0;
    end else begin
      if (out_valid_reg && out_ready) begin
        word_cnt_reg <= word_cnt_reg + 32'd1;
      end
      if (seed_load) begin
        lfsr_reg      <= seed_state;
        mode_reg      <= mode;
        out_valid_reg <= 1'b0;
        err_pend_reg  <= 1'b0;
      end else if (adv) begin
        lfsr_reg      <= chain[DATA_W];
        out_data_reg  <= word_out;
        out_valid_reg <= 1'b1;
        err_pend_reg  <= 1'b0;
      end else begin
        if (!en && out_valid_reg && out_ready) begin
          out_valid_reg <= 1'b0;
        end
        if (err_inj) begin
          err_pend_reg <= 1'b1;
        end
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign word_cnt  = word_cnt_reg;

endmodule
